// File: rtl/lfsr_seed_gen.sv
// lfsr_seed_gen: builds a WIDTH-bit random grid seed from a free-running LFSR.
// Build option: define SEED_DENSITY_EN for ~25% live-cell density seeds.
module lfsr_seed_gen #(
  parameter int          WIDTH     = 64,
  parameter logic [31:0] SEED_INIT = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lfsr_begin,
  output logic [WIDTH-1:0] seed_out,
  output logic             seed_valid,
  output logic             busy,
  output logic [7:0]       gen_count
);

  localparam int CW = $clog2(WIDTH);

  // all-zero is the LFSR's lock-up state, so never start there
  localparam logic [31:0] INIT =
    (SEED_INIT == 32'd0) ? 32'h0000_0001 : SEED_INIT;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [31:0]      lfsr;
  logic             fb;
  logic             sbit;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_n;
  logic             fill_last;

  assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];

`ifdef SEED_DENSITY_EN
  assign sbit = lfsr[0] & lfsr[16];
`else
  assign sbit = lfsr[0];
`endif

  assign shift_n   = {shift_reg[WIDTH-2:0], sbit};
  assign fill_last = (state == FILL) && (cnt == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state: a fill always runs to completion once started
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (lfsr_begin) state_n = FILL;
      FILL: if (fill_last)  state_n = DONE;
      DONE: state_n = lfsr_begin ? FILL : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs decoded from state: DONE lasts exactly one cycle
  always_comb begin
    busy       = (state != IDLE);
    seed_valid = (state == DONE);
  end

  // free-running LFSR; button timing relative to it supplies entropy
  always_ff @(posedge clk) begin
    if (reset) lfsr <= INIT;
    else       lfsr <= {lfsr[30:0], fb};
  end

  // shift in one seed bit per FILL cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      shift_reg <= '0;
    end else if (state == FILL) begin
      cnt       <= cnt + CW'(1);
      shift_reg <= shift_n;
    end else begin
      cnt       <= '0;
    end
  end

  // publish the whole seed at once so a partial seed is never seen
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_out  <= '0;
      gen_count <= 8'd0;
    end else if (fill_last) begin
      seed_out  <= shift_n;
      gen_count <= gen_count + 8'd1;
    end
  end

endmodule

// File: doc/lfsr_seed_gen.md
Name: lfsr_seed_gen

Overview:
- Downstream consumer of the game control FSM's lfsr_begin output.
- Generates a WIDTH-bit random initial grid seed from a free-running 32-bit LFSR, one bit per cycle.
- Presents the seed atomically on seed_out with a one-cycle seed_valid strobe.
- The top-level seed mux selects seed_out whenever show_rand_seed is high.

Parameters:
WIDTH, 64, number of seed bits (grid cells); legal range 2..256
SEED_INIT, 32'h0000_0001, LFSR reset value; 0 is replaced by 32'h0000_0001

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
lfsr_begin  input  1  level request from control FSM; high = generate/regenerate seeds
seed_out  output  WIDTH  last completed seed; bit WIDTH-1 = first bit generated
seed_valid  output  1  one-cycle pulse when seed_out has just been updated
busy  output  1  high while a fill is in progress (FILL or DONE state)
gen_count  output  8  number of seeds produced since reset, wraps 255->0

Behaviour:
- Reset (sync, active-high) sets:
  - lfsr = SEED_INIT, or 1 if SEED_INIT == 0
  - shift_reg = 0, seed_out = 0, seed_valid = 0, busy = 0
  - cnt = 0, gen_count = 0, state = IDLE
- LFSR:
  - Fibonacci form, polynomial x^32+x^22+x^2+x+1.
  - Update: lfsr <= {lfsr[30:0], fb}, where fb = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0].
  - Advances on every non-reset edge, in every state. Button timing therefore supplies entropy.
  - Held at its init value while reset is high. Never reaches all-zero.
- Seed bit: sbit = lfsr[0], sampled before that edge's advance. See Optional Feature.
- IDLE:
  - If lfsr_begin = 1: state <= FILL, cnt <= 0, busy <= 1.
  - Otherwise remain in IDLE.
- FILL:
  - Each edge: shift_reg <= {shift_reg[WIDTH-2:0], sbit}; cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1:
    - seed_out <= {shift_reg[WIDTH-2:0], sbit}
    - seed_valid <= 1
    - gen_count <= gen_count + 1
    - state <= DONE
- DONE (one cycle):
  - seed_valid <= 0.
  - If lfsr_begin = 1: state <= FILL, cnt <= 0.
  - Else: state <= IDLE, busy <= 0.
- Latency:
  - lfsr_begin sampled high in IDLE at edge E0 -> seed_out/seed_valid update at edge E0+WIDTH.
  - Regeneration period while lfsr_begin stays high: WIDTH+1 cycles.
- seed_out changes only at fill completion; a partial seed is never visible. Holds its value indefinitely otherwise.
- lfsr_begin falling during FILL: the fill is not aborted; it completes and publishes, then goes to IDLE.
- lfsr_begin glitch (high for 1 cycle in IDLE): one full seed is generated.
- Reset mid-FILL: fill is aborted. All outputs return to reset values the next cycle, including seed_out = 0.
- cnt width: clog2(WIDTH) bits. No other arithmetic; gen_count wraps modulo 256.

Optional Feature:
- Macro: SEED_DENSITY_EN.
- Defined: sbit = lfsr[0] & lfsr[16], giving approximately 25% live-cell density for sparser starting grids.
- Undefined: sbit = lfsr[0] (approximately 50% density).
- All timing, handshake and reset behaviour is identical in both builds.

Test Plan:
1. WIDTH=8, SEED_INIT=1; reset high 2 cycles; drop reset with lfsr_begin=1 before the first non-reset edge E0 -> seed_valid high for exactly one cycle after E8, seed_out=8'hB6, gen_count=1, busy high from E0+1 through the DONE cycle.
2. Same as 1 but built with SEED_DENSITY_EN -> seed_out=8'h00 after E8, seed_valid pulse identical in timing.
3. WIDTH=8, hold lfsr_begin=1 for 40 cycles -> seed_valid pulses every 9 cycles, gen_count increments by 1 per pulse, seed_out stable between pulses.
4. Pulse lfsr_begin for one cycle, then drop it mid-fill -> fill completes, a single seed_valid pulse 8 edges later, then IDLE with busy=0.
5. Assert reset at cnt=4 during FILL -> next cycle seed_out=0, seed_valid=0, busy=0, gen_count=0, lfsr=SEED_INIT.
6. SEED_INIT=0; run 300 seeds with lfsr_begin held high -> LFSR never all-zero, gen_count wraps from 255 to 0 and reads 44 at the end.
